dir_input_debounce: RTL and testbench

//  Consumes the 1 ms toggle produced by the millisecond timer and four raw

---
 rtl/dir_input_debounce_pkg.sv | 51 +++++
 rtl/dir_input_debounce_ch.sv | 81 ++++++++
 rtl/dir_input_debounce.sv | 119 +++++++++++
 tb/tb_dir_input_debounce.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dir_input_debounce_pkg.sv
// Shared codes, button indices, FSM encoding and priority helpers for the
// direction-button front end.
package dir_input_debounce_pkg;

  // Direction codes presented on dir_code
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Bit positions of each button in btn_raw / btn_state / pending
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  // Output handshake FSM
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } fsm_state_t;

  // Highest-priority pending button (up > down > left > right) as a direction code
  function automatic logic [1:0] pick_code(input logic [3:0] pend);
    logic [1:0] code;
    if (pend[BTN_UP]) begin
      code = DIR_UP;
    end else if (pend[BTN_DOWN]) begin
      code = DIR_DOWN;
    end else if (pend[BTN_LEFT]) begin
      code = DIR_LEFT;
    end else begin
      code = DIR_RIGHT;
    end
    return code;
  endfunction

  // One-hot pending-bit mask belonging to a direction code
  function automatic logic [3:0] code_mask(input logic [1:0] code);
    logic [3:0] mask;
    case (code)
      DIR_UP:    mask = 4'b1000;
      DIR_DOWN:  mask = 4'b0100;
      DIR_LEFT:  mask = 4'b0010;
      DIR_RIGHT: mask = 4'b0001;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dir_input_debounce_ch.sv
// One button channel: two-flop synchroniser, tick-based debounce and
// auto-repeat. o_evt pulses for one clk on a debounced press or a repeat.
module btn_debounce_ch #(
  parameter int DEBOUNCE_MS = 20,
  parameter int REPEAT_MS   = 200,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_state,
  output logic o_evt
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_MS - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_MS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_state;
  logic [CNT_W-1:0] r_deb_cnt;
  logic [CNT_W-1:0] r_rep_cnt;

  logic             w_differ;
  logic             w_flip;
  logic             w_rise;
  logic             w_fall;
  logic             w_rep_hit;
  logic [CNT_W-1:0] w_deb_nxt;
  logic [CNT_W-1:0] w_rep_nxt;

  // Debounce/repeat decisions and next counter values; a flip happens on the
  // tick that would bring deb_cnt up to DEBOUNCE_MS, a repeat likewise.
  always_comb begin
    w_differ  = (r_sync2 != r_state);
    w_flip    = w_differ && i_tick && (r_deb_cnt == DEB_LAST);
    w_rise    = w_flip && !r_state;
    w_fall    = w_flip && r_state;
    w_rep_hit = r_state && !w_fall && i_tick && (r_rep_cnt == REP_LAST);

    if (!w_differ || w_flip) begin
      w_deb_nxt = CNT_ZERO;
    end else if (i_tick) begin
      w_deb_nxt = r_deb_cnt + CNT_ONE;
    end else begin
      w_deb_nxt = r_deb_cnt;
    end

    if (w_rise || w_fall || w_rep_hit) begin
      w_rep_nxt = CNT_ZERO;
    end else if (r_state && i_tick) begin
      w_rep_nxt = r_rep_cnt + CNT_ONE;
    end else begin
      w_rep_nxt = r_rep_cnt;
    end
  end

  // Synchroniser, debounced level and both counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_state   <= 1'b0;
      r_deb_cnt <= CNT_ZERO;
      r_rep_cnt <= CNT_ZERO;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_state   <= r_state ^ w_flip;
      r_deb_cnt <= w_deb_nxt;
      r_rep_cnt <= w_rep_nxt;
    end
  end

  assign o_state = r_state;
  assign o_evt   = w_rise | w_rep_hit;

endmodule

// File: rtl/dir_input_debounce.sv
// Direction-button front end: ms tick recovery, four debounce channels,
// coalescing pending bits and a valid/ready offer FSM.
module dir_input_debounce
  import dir_input_debounce_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int REPEAT_MS   = 200,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_1ms,
  input  logic [3:0] btn_raw,
  input  logic       dir_ready,
  output logic       dir_valid,
  output logic [1:0] dir_code,
  output logic [3:0] btn_state,
  output logic       tick_ms
);

  logic       r_ms_s1;
  logic       r_ms_s2;
  logic       r_ms_s3;
  logic       r_tick;
  logic [3:0] r_pending;
  fsm_state_t r_fsm;
  logic       r_valid;
  logic [1:0] r_code;

  logic [3:0] w_state;
  logic [3:0] w_evt;
  logic [3:0] w_clr;
  fsm_state_t w_fsm_nxt;
  logic       w_valid_nxt;
  logic [1:0] w_code_nxt;

  // Synchronise the ms toggle and turn each of its edges into a registered pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ms_s1 <= 1'b0;
      r_ms_s2 <= 1'b0;
      r_ms_s3 <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_ms_s1 <= clk_1ms;
      r_ms_s2 <= r_ms_s1;
      r_ms_s3 <= r_ms_s2;
      r_tick  <= r_ms_s2 ^ r_ms_s3;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .REPEAT_MS   (REPEAT_MS),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_tick  (r_tick),
      .i_raw   (btn_raw[g]),
      .o_state (w_state[g]),
      .o_evt   (w_evt[g])
    );
  end

  // Next-state and next-output logic of the offer FSM
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_valid_nxt = r_valid;
    w_code_nxt  = r_code;
    w_clr       = 4'b0000;
    case (r_fsm)
      ST_IDLE: begin
        if (r_pending != 4'b0000) begin
          w_code_nxt  = pick_code(r_pending);
          w_clr       = code_mask(w_code_nxt);
          w_valid_nxt = 1'b1;
          w_fsm_nxt   = ST_OFFER;
        end else begin
          w_valid_nxt = 1'b0;
        end
      end
      ST_OFFER: begin
        if (dir_ready) begin
          w_valid_nxt = 1'b0;
          w_fsm_nxt   = ST_IDLE;
        end else begin
          w_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_valid_nxt = 1'b0;
        w_fsm_nxt   = ST_IDLE;
      end
    endcase
  end

  // FSM state, registered handshake outputs and pending bits (a new event beats a same-cycle clear)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm     <= ST_IDLE;
      r_valid   <= 1'b0;
      r_code    <= 2'd0;
      r_pending <= 4'b0000;
    end else begin
      r_fsm     <= w_fsm_nxt;
      r_valid   <= w_valid_nxt;
      r_code    <= w_code_nxt;
      r_pending <= (r_pending & ~w_clr) | w_evt;
    end
  end

  assign dir_valid = r_valid;
  assign dir_code  = r_code;
  assign btn_state = w_state;
  assign tick_ms   = r_tick;

endmodule

// File: tb/tb_dir_input_debounce.sv
// Directed, table-driven bench for dir_input_debounce (DEBOUNCE_MS=3, REPEAT_MS=5).
module tb_dir_input_debounce;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_1ms = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic       dir_ready = 1'b0;
  logic       dir_valid;
  logic [1:0] dir_code;
  logic [3:0] btn_state;
  logic       tick_ms;

  int n_checks = 0;
  int n_errors = 0;
  bit ms_run = 1'b0;
  int ms_cnt = 0;
  logic [1:0] ev_q[$];

  typedef struct {
    logic [3:0] btn;
    int         n_ev;
    logic [7:0] codes;  // first expected code in [7:6]
  } vec_t;
  vec_t vecs[6];

  dir_input_debounce #(
    .DEBOUNCE_MS (3),
    .REPEAT_MS   (5),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_1ms   (clk_1ms),
    .btn_raw   (btn_raw),
    .dir_ready (dir_ready),
    .dir_valid (dir_valid),
    .dir_code  (dir_code),
    .btn_state (btn_state),
    .tick_ms   (tick_ms)
  );

  always #5 clk = ~clk;

  // ms toggle every 10 clk once enabled
  initial begin
    forever begin
      @(negedge clk);
      if (ms_run) begin
        if (ms_cnt == 9) begin
          clk_1ms = ~clk_1ms;
          ms_cnt = 0;
        end else begin
          ms_cnt++;
        end
      end
    end
  end

  // record every accepted event
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && dir_valid && dir_ready) ev_q.push_back(dir_code);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bit seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        #1;
        if (tick_ms) seen = 1'b1;
      end
      if (!seen) begin
        n_checks++;
        n_errors++;
        $display("FAIL tick_timeout: got no tick_ms expected one within 40 clk");
      end
    end
  endtask

  task automatic wait_valid(input int maxc, output bit got);
    got = 1'b0;
    for (int c = 0; c < maxc && !got; c++) begin
      @(negedge clk);
      #1;
      if (dir_valid) got = 1'b1;
    end
  endtask

  function automatic logic [1:0] q_at(input int k);
    logic [1:0] v;
    v = 2'bxx;
    if (k < ev_q.size()) v = ev_q[k];
    return v;
  endfunction

  initial begin
    bit   got;
    int   bad;
    logic [7:0] cw;

    vecs[0] = '{4'b1000, 1, 8'b00_000000};
    vecs[1] = '{4'b0011, 2, 8'b10_11_0000};
    vecs[2] = '{4'b1100, 2, 8'b00_01_0000};
    vecs[3] = '{4'b1111, 4, 8'b00_01_10_11};
    vecs[4] = '{4'b0101, 2, 8'b01_11_0000};
    vecs[5] = '{4'b0001, 1, 8'b11_000000};

    // reset state
    repeat (5) @(negedge clk);
    #1;
    check("rst_valid", dir_valid, 1'b0);
    check("rst_code", dir_code, 2'd0);
    check("rst_state", btn_state, 4'b0000);
    check("rst_tick", tick_ms, 1'b0);

    // no tick while clk_1ms static, then first tick 3 clk after its edge
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (tick_ms) bad++;
    end
    check("tick_static", bad, 0);
    @(negedge clk);
    clk_1ms = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("tick_lat_%0d", k), tick_ms, (k == 3) ? 1'b1 : 1'b0);
    end
    ms_cnt = 0;
    ms_run = 1'b1;

    // glitch of 2 ticks on up
    dir_ready = 1'b1;
    wait_ticks(1);
    btn_raw = 4'b1000;
    wait_ticks(2);
    btn_raw = 4'b0000;
    wait_ticks(4);
    check("glitch_state", btn_state, 4'b0000);
    check("glitch_events", ev_q.size(), 0);
    check("glitch_valid", dir_valid, 1'b0);

    // up held 3 ticks, stalled handshake
    dir_ready = 1'b0;
    wait_ticks(1);
    btn_raw = 4'b1000;
    wait_ticks(3);
    @(negedge clk);
    #1;
    check("up_state", btn_state, 4'b1000);
    btn_raw = 4'b0000;
    wait_valid(5, got);
    check("up_valid", got, 1'b1);
    check("up_code", dir_code, 2'd0);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      #1;
      if (!dir_valid || dir_code !== 2'd0) bad++;
    end
    check("stall_stable", bad, 0);
    @(negedge clk);
    dir_ready = 1'b1;
    @(negedge clk);
    #1;
    check("accept_drop", dir_valid, 1'b0);
    wait_ticks(3);
    check("up_events", ev_q.size(), 1);
    check("up_ev_code", q_at(0), 2'd0);

    // table: press patterns, expected event order
    for (int v = 0; v < 6; v++) begin
      ev_q.delete();
      wait_ticks(1);
      btn_raw = vecs[v].btn;
      wait_ticks(3);
      @(negedge clk);
      #1;
      check($sformatf("tbl%0d_state", v), btn_state, vecs[v].btn);
      btn_raw = 4'b0000;
      wait_ticks(5);
      check($sformatf("tbl%0d_release", v), btn_state, 4'b0000);
      check($sformatf("tbl%0d_count", v), ev_q.size(), vecs[v].n_ev);
      cw = vecs[v].codes;
      for (int k = 0; k < vecs[v].n_ev; k++) begin
        check($sformatf("tbl%0d_code%0d", v, k), q_at(k), cw[7 - 2 * k -: 2]);
      end
    end

    // auto-repeat: right held 25 ticks -> press + 4 repeats
    ev_q.delete();
    wait_ticks(1);
    btn_raw = 4'b0001;
    wait_ticks(25);
    btn_raw = 4'b0000;
    wait_ticks(6);
    check("rep_count", ev_q.size(), 5);
    for (int k = 0; k < 5; k++) check($sformatf("rep_code%0d", k), q_at(k), 2'd3);
    wait_ticks(6);
    check("rep_after_release", ev_q.size(), 5);

    // coalesce: stalled, right held 15 ticks -> exactly 2 events
    dir_ready = 1'b0;
    ev_q.delete();
    wait_ticks(1);
    btn_raw = 4'b0001;
    wait_ticks(15);
    btn_raw = 4'b0000;
    wait_ticks(5);
    check("coal_valid", dir_valid, 1'b1);
    check("coal_code", dir_code, 2'd3);
    @(negedge clk);
    dir_ready = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("coal_count", ev_q.size(), 2);
    check("coal_code0", q_at(0), 2'd3);
    check("coal_code1", q_at(1), 2'd3);
    check("coal_idle", dir_valid, 1'b0);

    // reset in the middle of an offer
    dir_ready = 1'b0;
    wait_ticks(1);
    btn_raw = 4'b0010;
    wait_ticks(3);
    @(negedge clk);
    #1;
    wait_valid(5, got);
    check("pre_rst_valid", got, 1'b1);
    check("pre_rst_code", dir_code, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", dir_valid, 1'b0);
    check("mid_rst_code", dir_code, 2'd0);
    check("mid_rst_state", btn_state, 4'b0000);
    check("mid_rst_tick", tick_ms, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    btn_raw = 4'b0000;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
